// File: rtl/mem_block_copier_pkg.sv
// Shared definitions for the block copier and other users of the 512-word RAM.
package mem_block_copier_pkg;

    localparam int RAM_ADDR_WIDTH = 9;
    localparam int RAM_DATA_WIDTH = 16;
    localparam int RAM_DEPTH      = 1 << RAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READ   = 2'b01,
        WRITE  = 2'b10,
        FINISH = 2'b11
    } copier_state_t;

endpackage

// File: rtl/ram512.sv
// Single-port word RAM: combinational read on address, write on rising clk while load=1.
module ram512
    import mem_block_copier_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Commit a write on the rising edge while load is asserted.
    always_ff @(posedge clk) begin
        if (load) begin
            mem[address] <= in;
        end
    end

    assign out = mem[address];

endmodule

// File: rtl/mem_block_copier.sv
// Block copier: reads a word from src+i, writes it to dst+i, two cycles per word,
// ascending i (forward copy, so overlapping dst>src ranges propagate the first words).
//
//   state  | meaning
//   IDLE   | waiting for start; bus quiet
//   READ   | drive src+i, capture read data into the buffer
//   WRITE  | drive dst+i with the buffer and load=1, advance i
//   FINISH | one-cycle done pulse, then back to IDLE
module mem_block_copier
    import mem_block_copier_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_load,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_done
);

    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] COUNT_ZERO = '0;

    copier_state_t state, next_state;

    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_inc;
    logic [ADDR_WIDTH-1:0] offset;

    // words_done doubles as the word index i; the low bits give the modulo offset.
    assign count_inc  = count_q + COUNT_ONE;
    assign offset     = count_q[ADDR_WIDTH-1:0];
    assign words_done = count_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == COUNT_ZERO) ? FINISH : READ;
                end
            end
            READ:    next_state = WRITE;
            WRITE:   next_state = (count_inc == len_q) ? FINISH : READ;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transfer parameters, data buffer and word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= length;
                        count_q <= '0;
                    end
                end
                READ:    buf_q   <= mem_rdata;
                WRITE:   count_q <= count_inc;
                default: ;
            endcase
        end
    end

    // Bus and status outputs decoded from state and counter only; no path from start.
    always_comb begin
        mem_address = '0;
        mem_load    = 1'b0;
        mem_wdata   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            READ: begin
                mem_address = src_q + offset;
                busy        = 1'b1;
            end
            WRITE: begin
                mem_address = dst_q + offset;
                mem_load    = 1'b1;
                mem_wdata   = buf_q;
                busy        = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier driving a ram512 responder, with a forward-copy array model.
module tb_mem_block_copier;
    import mem_block_copier_pkg::*;

    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;
    localparam int DEPTH = RAM_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr;
    logic [AW:0]   length;
    logic [AW-1:0] mem_address;
    logic          mem_load;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, done;
    logic [AW:0]   words_done;

    // bench-side port onto the RAM for preload and readback while the copier is idle
    logic          tb_sel;
    logic [AW-1:0] tb_addr;
    logic          tb_load;
    logic [DW-1:0] tb_din;
    logic [AW-1:0] ram_addr;
    logic          ram_load;
    logic [DW-1:0] ram_in;

    assign ram_addr = tb_sel ? tb_addr : mem_address;
    assign ram_load = tb_sel ? tb_load : mem_load;
    assign ram_in   = tb_sel ? tb_din  : mem_wdata;

    always #5 clk = ~clk;

    mem_block_copier dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .mem_address(mem_address), .mem_load(mem_load), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .words_done(words_done)
    );

    ram512 u_ram (
        .clk(clk), .address(ram_addr), .load(ram_load), .in(ram_in), .out(mem_rdata)
    );

    logic [DW-1:0] model [0:DEPTH-1];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int load_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_load === 1'b1 && !tb_sel) load_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        tb_sel = 1'b1; tb_addr = a; tb_din = d; tb_load = 1'b1;
        @(negedge clk);
        tb_load = 1'b0;
        model[a] = d;
    endtask

    task automatic ram_peek(input logic [AW-1:0] a, output logic [DW-1:0] d);
        tb_sel = 1'b1; tb_load = 1'b0; tb_addr = a;
        #1;
        d = mem_rdata;
    endtask

    task automatic check_mem(input string tag);
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            ram_peek(AW'(i), d);
            check(tag, {16'h0, d}, {16'h0, model[i]});
        end
    endtask

    task automatic model_copy(input int s, input int d, input int n);
        for (int i = 0; i < n; i++) model[(d + i) % DEPTH] = model[(s + i) % DEPTH];
    endtask

    task automatic start_copy(input int s, input int d, input int n);
        @(negedge clk);
        tb_sel = 1'b0; tb_load = 1'b0;
        src_addr = AW'(s); dst_addr = AW'(d); length = (AW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns number of cycles from the start edge to the observed done pulse.
    task automatic wait_done(input int n, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 2 * n + 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_copy(input string tag, input int s, input int d, input int n);
        int lat;
        start_copy(s, d, n);
        wait_done(n, lat);
        check({tag, "_latency"}, lat, 2 * n + 1);
        check({tag, "_words_done"}, {22'h0, words_done}, n);
        model_copy(s, d, n);
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'h0, busy}, 0);
    endtask

    initial begin
        int lat, d0, l0;
        logic [DW-1:0] rd;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        tb_sel = 1'b1; tb_addr = '0; tb_load = 1'b0; tb_din = '0;
        #12;
        check("rst_address", {23'h0, mem_address}, 0);
        check("rst_load", {31'h0, mem_load}, 0);
        check("rst_wdata", {16'h0, mem_wdata}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_words_done", {22'h0, words_done}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) ram_write(AW'(i), DW'($urandom));

        // basic two-word copy
        ram_write(9'h000, 16'hABAB);
        ram_write(9'h001, 16'hCDCD);
        run_copy("basic", 'h000, 'h100, 2);
        ram_peek(9'h100, rd); check("basic_w0", {16'h0, rd}, 32'hABAB);
        ram_peek(9'h101, rd); check("basic_w1", {16'h0, rd}, 32'hCDCD);

        // zero length: immediate done, no writes
        l0 = load_cnt;
        run_copy("len0", 'h055, 'h0AA, 0);
        check("len0_no_load", load_cnt, l0);

        // address wrap
        ram_write(9'h1FF, 16'h1111);
        ram_write(9'h000, 16'h2222);
        run_copy("wrap", 'h1FF, 'h0F0, 2);
        ram_peek(9'h0F0, rd); check("wrap_w0", {16'h0, rd}, 32'h1111);
        ram_peek(9'h0F1, rd); check("wrap_w1", {16'h0, rd}, 32'h2222);

        // overlap, forward copy
        ram_write(9'h000, 16'h0001);
        ram_write(9'h001, 16'h0002);
        ram_write(9'h002, 16'h0003);
        run_copy("overlap", 0, 1, 2);
        ram_peek(9'h001, rd); check("overlap_w1", {16'h0, rd}, 32'h0001);
        ram_peek(9'h002, rd); check("overlap_w2", {16'h0, rd}, 32'h0001);
        check_mem("mem_after_directed");

        // start while busy is ignored
        d0 = done_cnt;
        start_copy('h020, 'h140, 3);
        @(negedge clk);
        src_addr = 9'h1A0; dst_addr = 9'h010; length = 10'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("ignored_latency", lat, 7);
        check("ignored_words_done", {22'h0, words_done}, 3);
        model_copy('h020, 'h140, 3);
        repeat (12) @(negedge clk);
        check("ignored_single_done", done_cnt - d0, 1);
        check("ignored_busy", {31'h0, busy}, 0);
        check_mem("mem_after_ignored");

        // reset during the second WRITE cycle
        d0 = done_cnt;
        start_copy('h060, 'h180, 4);
        repeat (3) @(negedge clk);
        check("midrst_in_write", {31'h0, mem_load}, 1);
        reset = 1'b1;
        #1;
        check("midrst_load", {31'h0, mem_load}, 0);
        check("midrst_busy", {31'h0, busy}, 0);
        check("midrst_done", {31'h0, done}, 0);
        check("midrst_address", {23'h0, mem_address}, 0);
        check("midrst_wdata", {16'h0, mem_wdata}, 0);
        check("midrst_words_done", {22'h0, words_done}, 0);
        @(negedge clk);
        reset = 1'b0;
        model_copy('h060, 'h180, 1);
        repeat (4) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check_mem("mem_after_midrst");

        // randomized transfers against the array model
        for (int t = 0; t < 6; t++) begin
            run_copy("rand", int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)));
        end
        check_mem("mem_after_random");

        // whole-RAM copy with wrap
        run_copy("full", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), DEPTH);
        check_mem("mem_after_full");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
